// File: rtl/data_pkg.sv
// rtl/data_pkg.sv - shared types and constants for the data_sel_reg slice
package data_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/data_sel_reg_if.sv
// rtl/data_sel_reg_if.sv - channel inputs, output handshake and status bundle
interface data_sel_reg_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int CNT_W    = 8
);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_ready;
  logic [CNT_W-1:0]          xfer_cnt;

  // Sources and consumer side.
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, xfer_cnt
  );

  // Selector register side.
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, xfer_cnt
  );

endinterface

// File: rtl/data_rr_arb.sv
// rtl/data_rr_arb.sv - combinational fixed-index / round-robin channel grant
module data_rr_arb
  import data_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  output logic                gnt_valid,
  output logic [SEL_W-1:0]    gnt_idx
);

  // Pick one channel; in round-robin the search runs farthest-first so the
  // nearest valid channel after ptr is the last (winning) assignment.
  always_comb begin
    int c;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    if (mode == MODE_FIXED) begin
      // Comparing against every legal index means an out-of-range sel never matches.
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SEL_W'(k);
        end
      end
    end else begin
      for (int i = CHANNELS; i >= 1; i--) begin
        c = int'(ptr) + i;
        if (c >= CHANNELS) c = c - CHANNELS;
        for (int k = 0; k < CHANNELS; k++) begin
          if (k == c && in_valid[k]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SEL_W'(k);
          end
        end
      end
    end
  end

endmodule

// File: rtl/data_sel_reg.sv
// rtl/data_sel_reg.sv - arbitrated single-entry output register with valid/ready
module data_sel_reg
  import data_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           rst_n,
  data_sel_reg_if.slave bus
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q;
  logic [SEL_W-1:0]    out_ch_q;
  logic [WIDTH-1:0]    out_data_q;
  logic [CNT_W-1:0]    xfer_cnt_q;
  logic                gnt_valid;
  logic [SEL_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]    gnt_data;
  logic [CHANNELS-1:0] in_ready;
  logic                slot_free;
  logic                accept;
  logic                drain;

  data_rr_arb #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .in_valid  (bus.in_valid),
    .ptr       (ptr_q),
    .mode      (bus.mode),
    .sel       (bus.sel),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // The slot can take a word when empty or when the held word leaves this cycle;
  // this is the intentional out_ready -> in_ready combinational path.
  assign slot_free = (state_q == EMPTY) || bus.out_ready;
  assign accept    = rst_n && gnt_valid && slot_free;
  assign drain     = (state_q == FULL) && bus.out_ready;

  // Steer ready to the granted channel only and mux out its data word.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        in_ready[k] = accept;
        gnt_data    = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: load wins over drain, so a simultaneous drain+fill stays FULL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)             state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Capture the granted word and remember its channel as the round-robin origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= SEL_W'(CHANNELS - 1);
    end else if (accept) begin
      out_data_q <= gnt_data;
      out_ch_q   <= gnt_idx;
      ptr_q      <= gnt_idx;
    end
  end

  // Count completed output transfers, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     xfer_cnt_q <= '0;
    else if (drain) xfer_cnt_q <= xfer_cnt_q + 1'b1;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_data_sel_reg.sv
// tb/tb_data_sel_reg.sv - self-checking bench for data_sel_reg in three configurations
module tb_data_sel_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [31:0] q4[$];

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [2:0] valid;
    logic [2:0] exp_rdy;
  } vec_t;

  vec_t tbl[9];

  data_sel_reg_if #(.WIDTH(2), .CHANNELS(2), .SEL_W(1), .CNT_W(8)) if2 ();
  data_sel_reg_if #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .CNT_W(8)) if4 ();
  data_sel_reg_if #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .CNT_W(2)) if3 ();

  data_sel_reg #(.WIDTH(2), .CHANNELS(2), .SEL_W(1), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));
  data_sel_reg #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave));
  data_sel_reg #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: pop one expected {ch,data} per output transfer.
  always @(negedge clk) begin
    if (rst_n && if2.out_valid && if2.out_ready) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb2_unexpected actual=%0h required=none", {if2.out_ch, if2.out_data});
      end else check("sb2_word", 32'({if2.out_ch, if2.out_data}), q2.pop_front());
    end
    if (rst_n && if4.out_valid && if4.out_ready) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb4_unexpected actual=%0h required=none", {if4.out_ch, if4.out_data});
      end else check("sb4_word", 32'({if4.out_ch, if4.out_data}), q4.pop_front());
    end
    if (rst_n && if3.out_valid && if3.out_ready) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb3_unexpected actual=%0h required=none", {if3.out_ch, if3.out_data});
      end else check("sb3_word", 32'({if3.out_ch, if3.out_data}), q3.pop_front());
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0] = '{1'b0, 2'd0, 3'b111, 3'b001};
    tbl[1] = '{1'b0, 2'd2, 3'b111, 3'b100};
    tbl[2] = '{1'b0, 2'd3, 3'b111, 3'b000};
    tbl[3] = '{1'b0, 2'd1, 3'b101, 3'b000};
    tbl[4] = '{1'b1, 2'd0, 3'b111, 3'b001};
    tbl[5] = '{1'b1, 2'd0, 3'b110, 3'b010};
    tbl[6] = '{1'b1, 2'd0, 3'b100, 3'b100};
    tbl[7] = '{1'b1, 2'd0, 3'b000, 3'b000};
    tbl[8] = '{1'b0, 2'd2, 3'b011, 3'b000};

    rst_n = 1'b0;
    if2.mode = 1'b0; if2.sel = '0; if2.in_valid = '0; if2.in_data = '0; if2.out_ready = 1'b0;
    if4.mode = 1'b0; if4.sel = '0; if4.in_valid = '0; if4.in_data = '0; if4.out_ready = 1'b0;
    if3.mode = 1'b0; if3.sel = '0; if3.in_valid = '0; if3.in_data = '0; if3.out_ready = 1'b0;
    #1;
    check("rst_out_valid", if2.out_valid, 0);
    check("rst_out_data", if2.out_data, 0);
    check("rst_out_ch", if4.out_ch, 0);
    check("rst_xfer_cnt", if4.xfer_cnt, 0);
    tick; tick;
    rst_n = 1'b1;

    // Table: in_ready from an idle CHANNELS=3 instance, ptr = 2 after reset.
    for (int i = 0; i < 9; i++) begin
      if3.mode = tbl[i].mode; if3.sel = tbl[i].sel; if3.in_valid = tbl[i].valid;
      #1;
      check($sformatf("tbl%0d_in_ready", i), if3.in_ready, tbl[i].exp_rdy);
      if3.in_valid = '0;
      tick;
    end
    check("tbl_no_accept", if3.out_valid, 0);

    // Out-of-range sel held across edges: no grant, stays EMPTY.
    if3.mode = 1'b0; if3.sel = 2'd3; if3.in_valid = 3'b111;
    tick; tick;
    check("oor_in_ready", if3.in_ready, 0);
    check("oor_empty", if3.out_valid, 0);
    if3.in_valid = '0;

    // Fixed select of channel 1 at full throughput.
    if2.mode = 1'b0; if2.sel = 1'b1; if2.in_valid = 2'b11; if2.in_data = 4'b10_01; if2.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fix_in_ready", if2.in_ready, 2'b10);
      q2.push_back(32'(1 * 4 + 2));
      tick;
      check("fix_out_valid", if2.out_valid, 1);
      check("fix_out_data", if2.out_data, 2'b10);
      check("fix_out_ch", if2.out_ch, 1);
    end
    if2.in_valid = '0;
    tick;
    check("fix_drained", if2.out_valid, 0);
    check("fix_xfer_cnt", if2.xfer_cnt, 3);
    if2.out_ready = 1'b0;

    // Round-robin over four always-valid channels.
    if4.mode = 1'b1; if4.in_valid = 4'hF; if4.in_data = 8'b11_10_01_00; if4.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_in_ready", if4.in_ready, 32'(1 << (k % 4)));
      q4.push_back(32'((k % 4) * 4 + (k % 4)));
      tick;
      check("rr_out_ch", if4.out_ch, 32'(k % 4));
    end
    if4.in_valid = '0;
    tick;
    check("rr_xfer_cnt", if4.xfer_cnt, 8);
    check("rr_drained", if4.out_valid, 0);

    // Backpressure: held word survives changing inputs.
    if4.mode = 1'b0; if4.sel = 2'd1; if4.out_ready = 1'b0; if4.in_valid = 4'b0010;
    #1;
    check("bp_in_ready_empty", if4.in_ready, 4'b0010);
    q4.push_back(32'(1 * 4 + 1));
    tick;
    check("bp_full", if4.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      if4.in_data = 8'($urandom);
      #1;
      check("bp_in_ready", if4.in_ready, 0);
      tick;
      check("bp_hold_data", if4.out_data, 2'b01);
      check("bp_hold_ch", if4.out_ch, 1);
      check("bp_hold_cnt", if4.xfer_cnt, 8);
    end
    if4.in_valid = '0; if4.in_data = 8'b11_10_01_00; if4.out_ready = 1'b1;
    tick;
    check("bp_release_cnt", if4.xfer_cnt, 9);
    check("bp_release_empty", if4.out_valid, 0);
    tick;
    check("bp_counted_once", if4.xfer_cnt, 9);

    // Simultaneous drain and fill from channel 2, no bubble.
    if4.mode = 1'b1; if4.in_valid = 4'b0100;
    #1;
    check("sim_in_ready_first", if4.in_ready, 4'b0100);
    q4.push_back(32'(2 * 4 + 2));
    tick;
    check("sim_full", if4.out_valid, 1);
    if4.in_data = 8'b11_11_01_00;
    #1;
    check("sim_in_ready_reload", if4.in_ready, 4'b0100);
    q4.push_back(32'(2 * 4 + 3));
    tick;
    check("sim_no_bubble", if4.out_valid, 1);
    check("sim_out_data", if4.out_data, 2'b11);
    check("sim_xfer_cnt", if4.xfer_cnt, 10);
    if4.in_valid = '0;
    tick;
    check("sim_final_cnt", if4.xfer_cnt, 11);
    check("sim_drained", if4.out_valid, 0);
    if4.out_ready = 1'b0;

    // Counter wrap with CNT_W=2: five transfers leave 1.
    if3.mode = 1'b1; if3.in_valid = 3'b111; if3.in_data = 6'b10_01_00; if3.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("wrap_in_ready", if3.in_ready, 32'(1 << (k % 3)));
      q3.push_back(32'((k % 3) * 4 + (k % 3)));
      tick;
    end
    if3.in_valid = '0;
    tick;
    check("wrap_xfer_cnt", if3.xfer_cnt, 1);
    check("wrap_drained", if3.out_valid, 0);
    if3.out_ready = 1'b0;

    // Asynchronous reset while FULL with 2'b11 held.
    if2.mode = 1'b0; if2.sel = 1'b0; if2.in_data = 4'b00_11; if2.in_valid = 2'b01; if2.out_ready = 1'b0;
    tick;
    check("rst_pre_full", if2.out_valid, 1);
    check("rst_pre_data", if2.out_data, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", if2.out_valid, 0);
    check("arst_out_data", if2.out_data, 0);
    check("arst_xfer_cnt", if2.xfer_cnt, 0);
    check("arst_in_ready", if2.in_ready, 0);
    check("arst_xfer_cnt4", if4.xfer_cnt, 0);
    tick;
    rst_n = 1'b1;
    if2.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", if2.in_ready, 2'b01);
    q2.push_back(32'(0 * 4 + 3));
    tick;
    check("post_rst_valid", if2.out_valid, 1);
    check("post_rst_data", if2.out_data, 2'b11);
    if2.in_valid = '0;
    tick;
    check("post_rst_cnt", if2.xfer_cnt, 1);

    check("sb2_left", q2.size(), 0);
    check("sb3_left", q3.size(), 0);
    check("sb4_left", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
